// File: rtl/sampler_mix_pkg.sv
// Shared types and helpers for the sampler voice mixer: FSM state encoding,
// gain unity derivation and a width-generic signed saturator.
package sampler_mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SCALE,
        ST_OUT
    } mix_state_e;

    localparam int unsigned SAT_MAX_W = 128;
    typedef logic signed [SAT_MAX_W-1:0] sat_wide_t;

    function automatic int unsigned gain_unity(input int unsigned gain_w);
        return 32'd1 << (gain_w - 1);
    endfunction

    // Clamp x into the signed range of an out_w-bit word; out_w is a constant at every call site.
    function automatic sat_wide_t saturate(input sat_wide_t x, input int unsigned out_w);
        sat_wide_t hi;
        sat_wide_t lo;
        hi = (sat_wide_t'(1) <<< (out_w - 1)) - sat_wide_t'(1);
        lo = -(sat_wide_t'(1) <<< (out_w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/mix_scale_sat.sv
// One mixer channel: applies the master gain to the accumulated sum with a
// floor-rounding arithmetic shift, then saturates to the sample width.
module mix_scale_sat
    import sampler_mix_pkg::*;
#(
    parameter int unsigned ACC_W    = 36,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned SHIFT    = 14
) (
    input  logic signed [ACC_W-1:0]    acc_i,
    input  logic        [GAIN_W-1:0]   gain_i,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       clip_o
);

    localparam int unsigned SC_W = ACC_W + GAIN_W + 1;

    logic signed [SC_W-1:0] prod;
    logic signed [SC_W-1:0] scaled;
    sat_wide_t              wide;
    sat_wide_t              sat;

    assign prod     = SC_W'(acc_i) * SC_W'($signed({1'b0, gain_i}));
    assign scaled   = prod >>> SHIFT;
    assign wide     = sat_wide_t'(scaled);
    assign sat      = saturate(wide, SAMPLE_W);
    assign sample_o = sat[SAMPLE_W-1:0];
    assign clip_o   = (sat != wide);

endmodule

// File: rtl/sampler_voice_mixer.sv
// N-voice stereo mixer: reads each voice in turn, accumulates gained samples at
// full precision, scales by master gain, saturates and writes one {L,R} word.
module sampler_voice_mixer
    import sampler_mix_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned GAIN_W     = 8,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                       board_clk,
    input  logic                       reset,
    input  logic                       frame_req,
    output logic                       voice_rd_en,
    output logic [IDX_W-1:0]           voice_rd_idx,
    input  logic                       voice_rd_valid,
    input  logic                       voice_active,
    input  logic signed [SAMPLE_W-1:0] voice_data_l,
    input  logic signed [SAMPLE_W-1:0] voice_data_r,
    input  logic [GAIN_W-1:0]          voice_gain,
    input  logic [GAIN_W-1:0]          master_gain,
    input  logic                       mix_full,
    output logic                       mix_wr,
    output logic [2*SAMPLE_W-1:0]      mix_data,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun,
    output logic                       timeout,
    input  logic                       clear_status
);

    localparam int unsigned ACC_W      = SAMPLE_W + GAIN_W + 1 + $clog2(NUM_VOICES);
    localparam int unsigned PROD_W     = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAIN_UNITY = gain_unity(GAIN_W);
    localparam int unsigned SHIFT      = 2 * $clog2(GAIN_UNITY);

    mix_state_e                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [TO_W-1:0]           wait_q, wait_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [2*SAMPLE_W-1:0]     data_q, data_d;
    logic                      clip_q, ovr_q, to_q;
    logic                      clip_set, ovr_set, to_set, advance;
    logic signed [PROD_W-1:0]  prod_l, prod_r;
    logic signed [SAMPLE_W-1:0] sat_l, sat_r;
    logic                      clip_l, clip_r;

    assign prod_l = PROD_W'(voice_data_l) * PROD_W'($signed({1'b0, voice_gain}));
    assign prod_r = PROD_W'(voice_data_r) * PROD_W'($signed({1'b0, voice_gain}));

    mix_scale_sat #(.ACC_W(ACC_W), .GAIN_W(GAIN_W), .SAMPLE_W(SAMPLE_W), .SHIFT(SHIFT)) u_scale_l (
        .acc_i(acc_l_q), .gain_i(master_gain), .sample_o(sat_l), .clip_o(clip_l)
    );
    mix_scale_sat #(.ACC_W(ACC_W), .GAIN_W(GAIN_W), .SAMPLE_W(SAMPLE_W), .SHIFT(SHIFT)) u_scale_r (
        .acc_i(acc_r_q), .gain_i(master_gain), .sample_o(sat_r), .clip_o(clip_r)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        data_d      = data_q;
        clip_set    = 1'b0;
        to_set      = 1'b0;
        advance     = 1'b0;
        ovr_set     = frame_req && (state_q != ST_IDLE);
        voice_rd_en = 1'b0;
        mix_wr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            ST_REQ: begin
                voice_rd_en = 1'b1;
                wait_d      = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (voice_rd_valid) begin
                    advance = 1'b1;
                    if (voice_active) begin
                        acc_l_d = acc_l_q + ACC_W'(prod_l);
                        acc_r_d = acc_r_q + ACC_W'(prod_r);
                    end
                end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                    advance = 1'b1;
                    to_set  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (advance) begin
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                        state_d = ST_SCALE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            // Saturated result is registered on leaving SCALE so mix_data is valid on OUT entry.
            ST_SCALE: begin
                data_d   = {sat_l, sat_r};
                clip_set = clip_l | clip_r;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (!mix_full) begin
                    mix_wr  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            data_q  <= '0;
            clip_q  <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            data_q  <= data_d;
            clip_q  <= clip_set | (clip_q & ~clear_status);
            ovr_q   <= ovr_set  | (ovr_q  & ~clear_status);
            to_q    <= to_set   | (to_q   & ~clear_status);
        end
    end

    assign voice_rd_idx = idx_q;
    assign mix_data     = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign clip         = clip_q;
    assign overrun      = ovr_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_sampler_voice_mixer.sv
// Bench for sampler_voice_mixer: directed vector table, reset corner case and
// randomized frames checked against an arithmetic reference model.
module tb_sampler_voice_mixer;

    localparam int NV = 8;
    localparam int SW = 24;
    localparam int GW = 8;
    localparam int TO = 16;

    logic                 clk;
    logic                 rst;
    logic                 frame_req;
    logic                 voice_rd_en;
    logic [2:0]           voice_rd_idx;
    logic                 voice_rd_valid;
    logic                 voice_active;
    logic signed [SW-1:0] voice_data_l;
    logic signed [SW-1:0] voice_data_r;
    logic [GW-1:0]        voice_gain;
    logic [GW-1:0]        master_gain;
    logic                 mix_full;
    logic                 mix_wr;
    logic [2*SW-1:0]      mix_data;
    logic                 busy;
    logic                 clip;
    logic                 overrun;
    logic                 timeout;
    logic                 clear_status;

    sampler_voice_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW), .TIMEOUT(TO)
    ) dut (
        .board_clk(clk), .reset(rst), .frame_req(frame_req),
        .voice_rd_en(voice_rd_en), .voice_rd_idx(voice_rd_idx),
        .voice_rd_valid(voice_rd_valid), .voice_active(voice_active),
        .voice_data_l(voice_data_l), .voice_data_r(voice_data_r),
        .voice_gain(voice_gain), .master_gain(master_gain),
        .mix_full(mix_full), .mix_wr(mix_wr), .mix_data(mix_data),
        .busy(busy), .clip(clip), .overrun(overrun), .timeout(timeout),
        .clear_status(clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Voice source contents; vlat = cycles from read strobe to valid, 0 = never answers.
    logic signed [SW-1:0] vl[NV];
    logic signed [SW-1:0] vr[NV];
    int                   vg[NV];
    bit                   vact[NV];
    int                   vlat[NV];
    int                   mg;

    int n_pass;
    int n_total;

    typedef struct {
        int          n_act;
        logic [23:0] l;
        logic [23:0] r;
        int          g;
        int          mgain;
        int          stall;
        int          req_at;
        bit          clr_hold;
        int          slow_v;
        int          slow_lat;
        logic [23:0] el;
        logic [23:0] er;
        bit          eclip;
        bit          eto;
        bit          eov;
        int          ewr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s (case %0d): got %0h, required %0h", nm, id, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural source: answers each read strobe after vlat cycles, drives junk otherwise.
    initial begin
        int cd;
        int pidx;
        cd = 0;
        pidx = 0;
        voice_rd_valid = 1'b0;
        voice_active = 1'b0;
        voice_data_l = '0;
        voice_data_r = '0;
        voice_gain = '0;
        forever begin
            @(negedge clk);
            voice_rd_valid = 1'b0;
            voice_active = 1'b1;
            voice_data_l = SW'($urandom);
            voice_data_r = SW'($urandom);
            voice_gain = GW'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    voice_rd_valid = 1'b1;
                    voice_active = vact[pidx];
                    voice_data_l = vl[pidx];
                    voice_data_r = vr[pidx];
                    voice_gain = GW'(vg[pidx]);
                end
            end
            if (voice_rd_en === 1'b1) begin
                pidx = int'(voice_rd_idx);
                cd = vlat[pidx];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input int stall, output logic [SW-1:0] el, output logic [SW-1:0] er,
                                  output bit eclip, output bit eto, output int ewr);
        longint al, ar, sl, sr, hi, lo;
        int waits;
        al = 0; ar = 0; waits = 0; eto = 0; eclip = 0;
        for (int i = 0; i < NV; i++) begin
            if (vlat[i] == 0 || vlat[i] > TO) begin
                eto = 1;
                waits += TO;
            end else begin
                waits += vlat[i];
                if (vact[i]) begin
                    al += longint'(vl[i]) * vg[i];
                    ar += longint'(vr[i]) * vg[i];
                end
            end
        end
        sl = (al * mg) >>> (2 * GW - 2);
        sr = (ar * mg) >>> (2 * GW - 2);
        hi = (longint'(1) << (SW - 1)) - 1;
        lo = -hi - 1;
        if (sl > hi) begin sl = hi; eclip = 1; end
        if (sl < lo) begin sl = lo; eclip = 1; end
        if (sr > hi) begin sr = hi; eclip = 1; end
        if (sr < lo) begin sr = lo; eclip = 1; end
        el = sl[SW-1:0];
        er = sr[SW-1:0];
        ewr = 1 + NV + waits + 1 + stall;
    endfunction

    task automatic load_pattern(input int n_act, input logic [SW-1:0] l, input logic [SW-1:0] r, input int g);
        for (int i = 0; i < NV; i++) begin
            vl[i] = l;
            vr[i] = r;
            vg[i] = g;
            vact[i] = (i < n_act);
            vlat[i] = 1;
        end
    endtask

    task automatic clear_flags(input int id);
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        #1;
        check("clear_flags", id, 64'({clip, overrun, timeout}), 64'd0);
    endtask

    task automatic run_frame(input int id, input int stall, input int req_at, input bit clr_hold,
                             input logic [SW-1:0] el, input logic [SW-1:0] er,
                             input bit eclip, input bit eto, input bit eov, input int ewr);
        int cyc, wr_cyc, wr_cnt, rd_cnt, bad_hold, out_cyc;
        logic [2*SW-1:0] exp_d, wr_data;
        logic busy_c1, busy_after;
        exp_d = {el, er};
        out_cyc = ewr - stall;
        wr_cyc = -1; wr_cnt = 0; rd_cnt = 0; bad_hold = 0;
        wr_data = '0; busy_c1 = 1'b0; busy_after = 1'b1;
        master_gain = GW'(mg);
        @(negedge clk);
        frame_req = 1'b1;
        mix_full = (stall > 0);
        clear_status = clr_hold;
        cyc = 0;
        while (cyc < ewr + 40) begin
            @(negedge clk);
            cyc++;
            frame_req = (cyc == req_at);
            if (stall > 0 && cyc >= out_cyc + stall) mix_full = 1'b0;
            #1;
            if (voice_rd_en === 1'b1) rd_cnt++;
            if (cyc == 1) busy_c1 = busy;
            if (clr_hold && cyc == out_cyc) check("clip_set_wins", id, 64'(clip), 64'(eclip));
            if (stall > 0 && cyc >= out_cyc && cyc < out_cyc + stall && (mix_data !== exp_d || mix_wr !== 1'b0))
                bad_hold++;
            if (mix_wr === 1'b1) begin
                wr_cnt++;
                if (wr_cyc < 0) begin
                    wr_cyc = cyc;
                    wr_data = mix_data;
                end
            end
            if (wr_cyc >= 0 && cyc == wr_cyc + 1) busy_after = busy;
            if (wr_cyc >= 0 && cyc >= wr_cyc + 3) break;
        end
        frame_req = 1'b0;
        mix_full = 1'b0;
        clear_status = 1'b0;
        check("wr_cycle", id, 64'(wr_cyc), 64'(ewr));
        check("wr_count", id, 64'(wr_cnt), 64'd1);
        check("mix_data", id, 64'(wr_data), 64'(exp_d));
        check("rd_count", id, 64'(rd_cnt), 64'(NV));
        check("busy_c1", id, 64'(busy_c1), 64'd1);
        check("busy_after", id, 64'(busy_after), 64'd0);
        check("clip", id, 64'(clip), 64'(eclip && !clr_hold));
        check("timeout", id, 64'(timeout), 64'(eto && !clr_hold));
        check("overrun", id, 64'(overrun), 64'(eov && !clr_hold));
        if (stall > 0) check("hold_data", id, 64'(bad_hold), 64'd0);
    endtask

    initial begin
        int wr_seen, busy_seen;
        logic [SW-1:0] el, er;
        bit eclip, eto;
        int ewr, stall;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        frame_req = 1'b0;
        mix_full = 1'b0;
        clear_status = 1'b0;
        master_gain = '0;
        mg = 128;
        load_pattern(0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 0, 64'({voice_rd_en, voice_rd_idx, mix_wr, mix_data, busy, clip, overrun, timeout}), 64'd0);
        rst = 1'b0;

        // Fields: n_act, l, r, g, mgain, stall, req_at, clr_hold, slow_v, slow_lat, el, er, eclip, eto, eov, ewr
        vecs[0] = '{1, 24'h000100, 24'hFFFF00, 128, 128, 0, -1, 1'b0, -1, 1, 24'h000100, 24'hFFFF00, 1'b0, 1'b0, 1'b0, 18};
        vecs[1] = '{8, 24'h400000, 24'hC00000, 128, 128, 0, -1, 1'b0, -1, 1, 24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 1'b0, 18};
        vecs[2] = '{1, 24'h001000, 24'hFFF000, 64, 128, 0, -1, 1'b0, -1, 1, 24'h000800, 24'hFFF800, 1'b0, 1'b0, 1'b0, 18};
        vecs[3] = '{1, 24'h001000, 24'hFFF000, 64, 0, 0, -1, 1'b0, -1, 1, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 18};
        vecs[4] = '{1, 24'h000100, 24'hFFFF00, 128, 128, 5, -1, 1'b0, -1, 1, 24'h000100, 24'hFFFF00, 1'b0, 1'b0, 1'b0, 23};
        vecs[5] = '{1, 24'h000100, 24'hFFFF00, 128, 128, 0, 5, 1'b0, -1, 1, 24'h000100, 24'hFFFF00, 1'b0, 1'b0, 1'b1, 18};
        vecs[6] = '{8, 24'h000010, 24'hFFFFE0, 128, 128, 0, -1, 1'b0, 3, 0, 24'h000070, 24'hFFFF20, 1'b0, 1'b1, 1'b0, 33};
        vecs[7] = '{1, 24'h000100, 24'hFFFF00, 128, 128, 0, -1, 1'b0, 0, 4, 24'h000100, 24'hFFFF00, 1'b0, 1'b0, 1'b0, 21};
        vecs[8] = '{1, 24'hFFFFFF, 24'h000001, 1, 1, 0, -1, 1'b0, -1, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b0, 18};
        vecs[9] = '{8, 24'h400000, 24'hC00000, 128, 128, 0, -1, 1'b1, -1, 1, 24'h7FFFFF, 24'h800000, 1'b1, 1'b0, 1'b0, 18};

        for (int v = 0; v < 10; v++) begin
            load_pattern(vecs[v].n_act, vecs[v].l, vecs[v].r, vecs[v].g);
            if (vecs[v].slow_v >= 0) vlat[vecs[v].slow_v] = vecs[v].slow_lat;
            mg = vecs[v].mgain;
            clear_flags(v);
            run_frame(v, vecs[v].stall, vecs[v].req_at, vecs[v].clr_hold, vecs[v].el, vecs[v].er,
                      vecs[v].eclip, vecs[v].eto, vecs[v].eov, vecs[v].ewr);
        end

        // Reset in the middle of a frame: everything returns to zero and no write follows.
        load_pattern(1, 24'h000100, 24'hFFFF00, 128);
        mg = 128;
        master_gain = GW'(mg);
        @(negedge clk);
        frame_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            frame_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("reset_mid", 50, 64'({voice_rd_en, voice_rd_idx, mix_wr, mix_data, busy, clip, overrun, timeout}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (mix_wr !== 1'b0) wr_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("no_wr_after_reset", 50, 64'(wr_seen), 64'd0);
        check("idle_after_reset", 50, 64'(busy_seen), 64'd0);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NV; i++) begin
                int r;
                vl[i] = SW'($urandom);
                vr[i] = SW'($urandom);
                if (k % 2 == 1) begin
                    vl[i] = vl[i] >>> 8;
                    vr[i] = vr[i] >>> 8;
                end
                vg[i] = int'($urandom_range(0, 255));
                vact[i] = ($urandom_range(0, 3) != 0);
                r = int'($urandom_range(0, 9));
                if (r == 0) vlat[i] = 0;
                else if (r <= 2) vlat[i] = int'($urandom_range(2, TO));
                else vlat[i] = 1;
            end
            mg = int'($urandom_range(0, 255));
            stall = int'($urandom_range(0, 3));
            model(stall, el, er, eclip, eto, ewr);
            clear_flags(100 + k);
            run_frame(100 + k, stall, -1, 1'b0, el, er, eclip, eto, 1'b0, ewr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sampler_voice_mixer.md
# sampler_voice_mixer

Parametrised N-voice stereo mixer between the sampler voice engines and the codec unit's playback data FIFO. On each frame request it reads every voice's left/right sample in turn, applies per-voice and master gain, sums at full precision, saturates, and writes one packed stereo word to the codec data path. It generalises the single fixed-width stereo write path to any voice count and sample width. It adds:

- back-pressure
- a voice-read timeout
- sticky status flags

## Interface
Parameters:
- NUM_VOICES, 8, voices mixed per frame (≥1)
- SAMPLE_W, 24, signed sample width per channel
- GAIN_W, 8, unsigned gain width; unity = 2^(GAIN_W-1)
- TIMEOUT, 16, max cycles waited for voice_rd_valid

Ports:
- board_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_req  in  1  one-cycle request for a new stereo frame
- voice_rd_en  out  1  one-cycle read strobe to voice source
- voice_rd_idx  out  $clog2(NUM_VOICES)  voice being read
- voice_rd_valid  in  1  voice data valid
- voice_active  in  1  voice playing; 0 contributes zero
- voice_data_l / voice_data_r  in  SAMPLE_W each  signed samples
- voice_gain  in  GAIN_W  per-voice gain, sampled with valid
- master_gain  in  GAIN_W  sampled in SCALE
- mix_full  in  1  downstream FIFO full
- mix_wr  out  1  one-cycle write strobe
- mix_data  out  2*SAMPLE_W  {L, R}
- busy  out  1  high outside IDLE
- clip / overrun / timeout  out  1 each  sticky flags
- clear_status  in  1  clears sticky flags

## Operation
FSM states and transitions:
- IDLE: frame_req → REQ; clears both accumulators and voice index.
- REQ: voice_rd_en = 1 for exactly one cycle, voice_rd_idx = index → WAIT.
- WAIT:
  - On voice_rd_valid: if voice_active, each accumulator += sample × voice_gain (signed × unsigned). Then the next index goes to REQ, or the last index goes to SCALE.
  - After TIMEOUT cycles without valid: voice contributes zero, timeout set, advance as above.
- SCALE: scaled = (acc × master_gain) >>> (2·GAIN_W−2), arithmetic shift, floor rounding → OUT.
- OUT: saturate each channel to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1] and register into mix_data. Any clamp sets clip. Hold while mix_full. When !mix_full, pulse mix_wr one cycle → IDLE.

Arithmetic rules:
- Accumulator width: SAMPLE_W+GAIN_W+1+$clog2(NUM_VOICES). Overflow is impossible.
- Scaled width: accumulator width + GAIN_W + 1.

Boundary behaviour:
- frame_req while busy: ignored, sets overrun.
- voice_rd_valid outside WAIT: ignored.
- clear_status together with a set event: set wins.
- reset, including mid-frame: all outputs 0, FSM to IDLE, accumulators cleared, no mix_wr.

## Timing
- Reset values: voice_rd_en, voice_rd_idx, mix_wr, mix_data, busy, clip, overrun, timeout all 0.
- frame_req sampled in IDLE at cycle 0:
  - voice i read at cycle 1+2i.
  - With 1-cycle source latency, valid arrives at 2+2i.
  - SCALE at 2N+1.
  - mix_wr at 2N+2 (cycle 18 for N=8) when mix_full is low.
- Each extra wait cycle adds one cycle to the total.
- mix_data is stable from OUT entry until the next frame's OUT.
- busy drops the cycle after mix_wr.
- The earliest next frame_req is accepted the cycle after mix_wr.

## Structure
- Shared package sampler_mix_pkg holds:
  - state enum
  - GAIN_UNITY localparam function of GAIN_W
  - saturate function parametrised by widths
- One sub-module, mix_scale_sat: master-gain multiply plus saturation for one channel, instantiated twice (L, R).

## Test plan
1. N=8, voice 0 active L=0x000100 R=0xFFFF00, gains 128, master 128, others inactive → mix_data={0x000100,0xFFFF00}, mix_wr at cycle 18, clip=0.
2. All 8 voices L=0x400000 R=0xC00000, gains 128 → L=0x7FFFFF, R=0x800000, clip=1; clear_status → clip=0.
3. Voice 0 L=0x001000, gain 64 → L=0x000800. Repeat with master 0 → mix_data=0.
4. mix_full held high 5 cycles at OUT → mix_wr delayed 5 cycles, single pulse, mix_data unchanged throughout.
5. frame_req pulsed at cycle 5 of a frame → overrun=1, exactly one mix_wr.
6. Voice 3 never returns valid, TIMEOUT=16 → timeout=1, voice 3 contributes 0, frame still written. Separately, reset asserted at cycle 7 → all outputs 0, busy=0, no mix_wr.
